// File: rtl/axi_pkg.sv
// Shared types, response codes and burst address arithmetic for the AXI memory responder.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  // Computed at 64 bits so any ADDR_WIDTH up to 64 can truncate the result.
  function automatic logic [63:0] axi_next_addr(input logic [63:0] addr,
                                                input logic [2:0]  size,
                                                input logic [7:0]  len,
                                                input burst_t      burst);
    logic [63:0] bytes;
    logic [63:0] total;
    logic [63:0] low;
    logic [63:0] nxt;
    bytes = 64'd1 << size;
    total = bytes * (64'(len) + 64'd1);
    low   = addr & ~(total - 64'd1);
    nxt   = addr;
    case (burst)
      BURST_INCR: nxt = (addr & ~(bytes - 64'd1)) + bytes;
      BURST_WRAP: begin
        nxt = addr + bytes;
        if (nxt == low + total) nxt = low;
      end
      default:    nxt = addr;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/axi_burst_ctr.sv
// Burst address and beat tracker: loads on the address handshake, steps on each beat handshake.
// LOOKAHEAD=1 exposes the values the registers are about to take, for the registered read path.
module axi_burst_ctr
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_W     = 4,
  parameter int MEM_DEPTH  = 1024,
  parameter bit LOOKAHEAD  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [7:0]            len_in,
  input  logic [2:0]            size_in,
  input  logic [1:0]            burst_in,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last,
  output logic                  err
);

  localparam int LG = $clog2(STRB_W);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH * STRB_W);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            rem_q, rem_d, len_q;
  logic [2:0]            size_q;
  burst_t                burst_q;
  logic                  berr_q, berr_d, berr_in;

  always_comb begin
    berr_in = (int'(size_in) > LG) || (burst_in == 2'd3) ||
              ((burst_in == 2'd2) && !(len_in inside {8'd1, 8'd3, 8'd7, 8'd15}));
    addr_d  = addr_q;
    rem_d   = rem_q;
    berr_d  = berr_q;
    if (load) begin
      addr_d = addr_in;
      rem_d  = len_in;
      berr_d = berr_in;
    end else if (advance) begin
      addr_d = ADDR_WIDTH'(axi_next_addr(64'(addr_q), size_q, len_q, burst_q));
      rem_d  = rem_q - 8'd1;
    end
  end

  // rem is a down-counter of beats still to go; the last beat is its terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      rem_q   <= '0;
      berr_q  <= 1'b0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= BURST_FIXED;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
      berr_q <= berr_d;
      if (load) begin
        len_q   <= len_in;
        size_q  <= size_in;
        burst_q <= burst_t'(burst_in);
      end
    end
  end

  assign addr = LOOKAHEAD ? addr_d : addr_q;
  assign last = (LOOKAHEAD ? rem_d : rem_q) == 8'd0;
  assign err  = (LOOKAHEAD ? berr_d : berr_q) || ({1'b0, addr} >= LIMIT);

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 memory responder with independent write and read burst engines over one word array.
//  state  | meaning
//  W_IDLE | awready high, waiting for a write address
//  W_DATA | wready high, accepting awlen+1 beats
//  W_RESP | bvalid high until bready
//  R_IDLE | arready high, waiting for a read address
//  R_DATA | streaming registered read beats until the rlast handshake
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LG     = $clog2(STRB_W);
  localparam int IDXW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  wstate_t w_state, w_next;
  rstate_t r_state, r_next;

  logic                  accept_en;
  logic                  aw_hs, w_hs, ar_hs, r_hs;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic                  wr_last, wr_err, rd_last, rd_err;
  logic                  wr_err_q;
  logic [IDXW-1:0]       wr_idx, rd_idx;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign ar_hs  = arvalid && arready;
  assign r_hs   = rvalid && rready;
  assign wr_idx = IDXW'(wr_addr >> LG);
  assign rd_idx = IDXW'(rd_addr >> LG);

  axi_burst_ctr #(
    .ADDR_WIDTH(ADDR_WIDTH), .STRB_W(STRB_W), .MEM_DEPTH(MEM_DEPTH), .LOOKAHEAD(1'b0)
  ) u_wr_ctr (
    .clk(clk), .rst_n(rst_n), .load(aw_hs), .advance(w_hs),
    .addr_in(awaddr), .len_in(awlen), .size_in(awsize), .burst_in(awburst),
    .addr(wr_addr), .last(wr_last), .err(wr_err)
  );

  axi_burst_ctr #(
    .ADDR_WIDTH(ADDR_WIDTH), .STRB_W(STRB_W), .MEM_DEPTH(MEM_DEPTH), .LOOKAHEAD(1'b1)
  ) u_rd_ctr (
    .clk(clk), .rst_n(rst_n), .load(ar_hs), .advance(r_hs),
    .addr_in(araddr), .len_in(arlen), .size_in(arsize), .burst_in(arburst),
    .addr(rd_addr), .last(rd_last), .err(rd_err)
  );

  // Keeps the address readies low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) accept_en <= 1'b0;
    else        accept_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && wr_last) w_next = W_RESP;
      W_RESP:  if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && rlast) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bresp   = RESP_OKAY;
    case (w_state)
      W_IDLE: awready = accept_en;
      W_DATA: wready  = 1'b1;
      W_RESP: begin
        bvalid = 1'b1;
        bresp  = wr_err_q ? RESP_SLVERR : RESP_OKAY;
      end
      default: ;
    endcase
    arready = accept_en && (r_state == R_IDLE);
    rvalid  = (r_state == R_DATA);
  end

  // A wlast disagreeing with the beat count flags the burst but does not block the byte writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bid      <= '0;
      wr_err_q <= 1'b0;
    end else if (aw_hs) begin
      bid      <= awid;
      wr_err_q <= 1'b0;
    end else if (w_hs && (wr_err || (wlast != wr_last))) begin
      wr_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !wr_err) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[wr_idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Read beats are fetched on the address or beat handshake edge, so a same-edge write is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rid   <= '0;
      rdata <= '0;
      rresp <= RESP_OKAY;
      rlast <= 1'b0;
    end else begin
      if (ar_hs) rid <= arid;
      if (ar_hs || (r_hs && !rlast)) begin
        rdata <= rd_err ? '0 : mem[rd_idx];
        rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
        rlast <= rd_last;
      end else if (r_hs) begin
        rlast <= 1'b0;
      end
    end
  end

endmodule
